// File: rtl/dram_mux_page_model.sv
// Cycle model of a multiplexed-address DRAM (4416-class and up).
// Row and column are captured from one shared address bus on /RAS and /CAS
// falling edges, detected against the master clock. Supports fast-page
// mode, RAS-only and CAS-before-RAS refresh, read-modify-write, and a
// refresh-starvation watchdog.
module dram_mux_page_model #(
  parameter int unsigned DW          = 4,
  parameter int unsigned AW          = 8,
  parameter int unsigned ROW_W       = 8,
  parameter int unsigned COL_W       = 6,
  parameter int unsigned COL_SHIFT   = 1,
  parameter int unsigned REF_TIMEOUT = 0,
  parameter string       INIT_FILE   = ""
) (
  input  logic             i_MCLK,
  input  logic             i_RST_n,
  input  logic [AW-1:0]    i_ADDR,
  input  logic [DW-1:0]    i_DIN,
  output logic [DW-1:0]    o_DOUT,
  output logic             o_DOUT_OE,
  input  logic             i_RAS_n,
  input  logic             i_CAS_n,
  input  logic             i_WR_n,
  input  logic             i_RD_n,
  output logic [ROW_W-1:0] o_REF_CNT,
  output logic             o_REF_ERR
);

  localparam int unsigned IDX_W = COL_W + ROW_W;
  localparam int unsigned DEPTH = 1 << IDX_W;
  localparam int unsigned WD_W  = (REF_TIMEOUT > 0) ? $clog2(REF_TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ROW  = 2'd1,
    ST_COL  = 2'd2,
    ST_CBR  = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_next;

  logic [DW-1:0]      r_mem [0:DEPTH-1];

  logic               r_prev_ras;
  logic               r_prev_cas;
  logic               r_ras_armed;
  logic               r_cas_armed;
  logic               r_cbr_pend;
  logic [ROW_W-1:0]   r_row;
  logic [COL_W-1:0]   r_col;
  logic [DW-1:0]      r_dout;
  logic               r_dout_oe;
  logic [ROW_W-1:0]   r_ref_cnt;
  logic               r_ref_err;
  logic [WD_W-1:0]    r_wd;

  logic               w_ras_fall;
  logic               w_ras_rise;
  logic               w_cas_fall;
  logic               w_cas_rise;
  logic               w_latch_row;
  logic               w_latch_col;
  logic               w_cbr_start;
  logic               w_access;
  logic               w_oe_clr;
  logic               w_cbr_pend_next;
  logic [WD_W-1:0]    w_wd_next;
  logic [IDX_W-1:0]   w_addr;

  // A strobe held low across reset release must rise once before its next
  // fall counts, so falls are qualified by an arm flag.
  assign w_ras_fall = r_prev_ras & ~i_RAS_n & r_ras_armed;
  assign w_ras_rise = ~r_prev_ras & i_RAS_n;
  assign w_cas_fall = r_prev_cas & ~i_CAS_n & r_cas_armed;
  assign w_cas_rise = ~r_prev_cas & i_CAS_n;

  assign w_addr = {r_col, r_row};

  always_ff @(posedge i_MCLK or negedge i_RST_n) begin
    if (!i_RST_n) r_state <= ST_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next    = r_state;
    w_latch_row     = 1'b0;
    w_latch_col     = 1'b0;
    w_cbr_start     = 1'b0;
    w_access        = 1'b0;
    w_oe_clr        = 1'b0;
    w_cbr_pend_next = r_cbr_pend;
    if (w_ras_rise) begin
      w_state_next    = ST_IDLE;
      w_oe_clr        = 1'b1;
      w_cbr_pend_next = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_ras_fall) begin
            w_cbr_pend_next = 1'b0;
            if (r_cbr_pend) begin
              w_state_next = ST_CBR;
              w_cbr_start  = 1'b1;
            end else if (w_cas_fall) begin
              w_state_next = ST_COL;
              w_latch_row  = 1'b1;
              w_latch_col  = 1'b1;
            end else begin
              w_state_next = ST_ROW;
              w_latch_row  = 1'b1;
            end
          end else if (w_cas_fall) begin
            w_cbr_pend_next = 1'b1;
          end else if (w_cas_rise) begin
            w_cbr_pend_next = 1'b0;
          end
        end
        ST_ROW: begin
          if (w_cas_fall) begin
            w_state_next = ST_COL;
            w_latch_col  = 1'b1;
          end
        end
        ST_COL: begin
          if (w_cas_rise) begin
            w_state_next = ST_ROW;
            w_oe_clr     = 1'b1;
          end else begin
            w_access = 1'b1;
          end
        end
        ST_CBR: begin
          w_state_next = ST_CBR;
        end
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_wd_next = r_wd;
    if (REF_TIMEOUT == 0)                   w_wd_next = '0;
    else if (w_ras_fall)                    w_wd_next = '0;
    else if (r_wd != WD_W'(REF_TIMEOUT))    w_wd_next = r_wd + 1'b1;
  end

  always_ff @(posedge i_MCLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      r_prev_ras  <= 1'b1;
      r_prev_cas  <= 1'b1;
      r_ras_armed <= 1'b0;
      r_cas_armed <= 1'b0;
      r_cbr_pend  <= 1'b0;
      r_row       <= '0;
      r_col       <= '0;
      r_ref_cnt   <= '0;
      r_wd        <= '0;
      r_ref_err   <= 1'b0;
    end else begin
      r_prev_ras  <= i_RAS_n;
      r_prev_cas  <= i_CAS_n;
      r_ras_armed <= r_ras_armed | i_RAS_n;
      r_cas_armed <= r_cas_armed | i_CAS_n;
      r_cbr_pend  <= w_cbr_pend_next;
      if (w_latch_row) r_row <= i_ADDR[ROW_W-1:0];
      if (w_latch_col) r_col <= i_ADDR[COL_SHIFT +: COL_W];
      if (w_cbr_start) r_ref_cnt <= r_ref_cnt + 1'b1;
      r_wd <= w_wd_next;
      if (REF_TIMEOUT != 0 && w_wd_next == WD_W'(REF_TIMEOUT)) r_ref_err <= 1'b1;
    end
  end

  always_ff @(posedge i_MCLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      r_dout    <= '0;
      r_dout_oe <= 1'b0;
    end else if (w_oe_clr) begin
      r_dout_oe <= 1'b0;
    end else if (w_access && !i_RD_n) begin
      r_dout_oe <= 1'b1;
      r_dout    <= i_WR_n ? r_mem[w_addr] : i_DIN;
    end
  end

  always_ff @(posedge i_MCLK) begin
    if (w_access && !i_WR_n) r_mem[w_addr] <= i_DIN;
  end

  assign o_DOUT    = r_dout;
  assign o_DOUT_OE = r_dout_oe;
  assign o_REF_CNT = r_ref_cnt;
  assign o_REF_ERR = r_ref_err;

endmodule

// File: tb/tb_dram_mux_page_model.sv
// Directed bench for dram_mux_page_model: inputs driven and outputs sampled
// on the falling clock edge; expected values are hand-derived constants.
module tb_dram_mux_page_model;

    logic       i_MCLK = 1'b0;
    logic       i_RST_n = 1'b0;
    logic [7:0] i_ADDR = '0;
    logic [3:0] i_DIN = '0;
    logic [3:0] o_DOUT;
    logic       o_DOUT_OE;
    logic       i_RAS_n = 1'b1;
    logic       i_CAS_n = 1'b1;
    logic       i_WR_n = 1'b1;
    logic       i_RD_n = 1'b1;
    logic [7:0] o_REF_CNT;
    logic       o_REF_ERR;

    int n_cmp = 0;
    int n_bad = 0;

    dram_mux_page_model #(
        .REF_TIMEOUT(100)
    ) dut (
        .i_MCLK    (i_MCLK),
        .i_RST_n   (i_RST_n),
        .i_ADDR    (i_ADDR),
        .i_DIN     (i_DIN),
        .o_DOUT    (o_DOUT),
        .o_DOUT_OE (o_DOUT_OE),
        .i_RAS_n   (i_RAS_n),
        .i_CAS_n   (i_CAS_n),
        .i_WR_n    (i_WR_n),
        .i_RD_n    (i_RD_n),
        .o_REF_CNT (o_REF_CNT),
        .o_REF_ERR (o_REF_ERR)
    );

    always #5 i_MCLK = ~i_MCLK;

    task automatic cyc(input int n);
        repeat (n) @(negedge i_MCLK);
    endtask

    task automatic ras_open(input logic [7:0] a);
        i_ADDR = a; i_RAS_n = 1'b0;
        cyc(1);
    endtask

    // CAS fall with strobes set up; returns after the first access clock.
    task automatic cas_open(input logic [7:0] a, input logic wr_n, input logic rd_n, input logic [3:0] d);
        i_ADDR = a; i_WR_n = wr_n; i_RD_n = rd_n; i_DIN = d; i_CAS_n = 1'b0;
        cyc(2);
    endtask

    task automatic cas_close();
        i_CAS_n = 1'b1; i_WR_n = 1'b1; i_RD_n = 1'b1;
        cyc(1);
    endtask

    task automatic ras_close();
        i_RAS_n = 1'b1;
        cyc(1);
    endtask

    task automatic do_write(input logic [7:0] row, input logic [7:0] ca, input logic [3:0] d);
        ras_open(row); cas_open(ca, 1'b0, 1'b1, d); cas_close(); ras_close();
    endtask

    task automatic do_read(input logic [7:0] row, input logic [7:0] ca, output logic [3:0] d, output logic oe);
        ras_open(row); cas_open(ca, 1'b1, 1'b0, 4'h0);
        d = o_DOUT; oe = o_DOUT_OE;
        cas_close(); ras_close();
    endtask

    task automatic do_cbr();
        i_CAS_n = 1'b0; cyc(1);
        i_RAS_n = 1'b0; i_WR_n = 1'b0; i_DIN = 4'hF; cyc(2);
        i_RAS_n = 1'b1; cyc(1);
        i_CAS_n = 1'b1; i_WR_n = 1'b1; cyc(1);
    endtask

    task automatic do_reset();
        i_RST_n = 1'b0; cyc(2);
        i_RST_n = 1'b1; cyc(1);
    endtask

    task automatic test_reset();
        cyc(2);
        n_cmp++; if (o_DOUT !== 4'h0)    begin n_bad++; $display("FAIL reset_dout: got %h want 0", o_DOUT); end
        n_cmp++; if (o_DOUT_OE !== 1'b0) begin n_bad++; $display("FAIL reset_oe: got %b want 0", o_DOUT_OE); end
        n_cmp++; if (o_REF_CNT !== 8'h00) begin n_bad++; $display("FAIL reset_refcnt: got %h want 00", o_REF_CNT); end
        n_cmp++; if (o_REF_ERR !== 1'b0) begin n_bad++; $display("FAIL reset_referr: got %b want 0", o_REF_ERR); end
        i_RST_n = 1'b1; cyc(2);
        n_cmp++; if (o_DOUT_OE !== 1'b0 || o_REF_CNT !== 8'h00) begin
            n_bad++; $display("FAIL post_reset_idle: got oe=%b ref=%h want oe=0 ref=00", o_DOUT_OE, o_REF_CNT);
        end
    endtask

    task automatic test_watchdog();
        for (int i = 0; i < 6; i++) begin
            i_RAS_n = 1'b0; cyc(1);
            i_RAS_n = 1'b1; cyc(49);
        end
        n_cmp++; if (o_REF_ERR !== 1'b0) begin n_bad++; $display("FAIL wd_fed: got %b want 0", o_REF_ERR); end
        cyc(110);
        n_cmp++; if (o_REF_ERR !== 1'b1) begin n_bad++; $display("FAIL wd_timeout: got %b want 1", o_REF_ERR); end
        for (int i = 0; i < 3; i++) begin
            i_RAS_n = 1'b0; cyc(2);
            i_RAS_n = 1'b1; cyc(8);
        end
        n_cmp++; if (o_REF_ERR !== 1'b1) begin n_bad++; $display("FAIL wd_sticky: got %b want 1", o_REF_ERR); end
        do_reset();
        n_cmp++; if (o_REF_ERR !== 1'b0) begin n_bad++; $display("FAIL wd_reset_clear: got %b want 0", o_REF_ERR); end
    endtask

    task automatic test_write_read();
        do_write(8'h12, 8'h0A, 4'h9);
        ras_open(8'h12);
        i_ADDR = 8'h0A; i_RD_n = 1'b0; i_CAS_n = 1'b0;
        cyc(1);
        n_cmp++; if (o_DOUT_OE !== 1'b0) begin n_bad++; $display("FAIL rd_latency_oe: got %b want 0", o_DOUT_OE); end
        cyc(1);
        n_cmp++; if (o_DOUT !== 4'h9)    begin n_bad++; $display("FAIL rd_data: got %h want 9", o_DOUT); end
        n_cmp++; if (o_DOUT_OE !== 1'b1) begin n_bad++; $display("FAIL rd_oe: got %b want 1", o_DOUT_OE); end
        cas_close(); ras_close();
        n_cmp++; if (o_DOUT_OE !== 1'b0 || o_DOUT !== 4'h9) begin
            n_bad++; $display("FAIL rd_close: got oe=%b dout=%h want oe=0 dout=9", o_DOUT_OE, o_DOUT);
        end
    endtask

    task automatic test_page_mode();
        logic [7:0] a;
        ras_open(8'h34);
        for (int c = 1; c <= 3; c++) begin
            a = 8'(c << 1);
            cas_open(a, 1'b0, 1'b1, 4'(c));
            cas_close();
        end
        ras_close();
        ras_open(8'h34);
        for (int c = 3; c >= 1; c--) begin
            a = 8'(c << 1);
            cas_open(a, 1'b1, 1'b0, 4'h0);
            n_cmp++; if (o_DOUT !== 4'(c)) begin n_bad++; $display("FAIL page_rd_col%0d: got %h want %h", c, o_DOUT, 4'(c)); end
            n_cmp++; if (o_DOUT_OE !== 1'b1) begin n_bad++; $display("FAIL page_oe_col%0d: got %b want 1", c, o_DOUT_OE); end
            cas_close();
            n_cmp++; if (o_DOUT_OE !== 1'b0) begin n_bad++; $display("FAIL page_oe_drop_col%0d: got %b want 0", c, o_DOUT_OE); end
        end
        ras_close();
    endtask

    task automatic test_cbr();
        logic [3:0] d;
        logic       oe;
        do_cbr();
        n_cmp++; if (o_REF_CNT !== 8'h01) begin n_bad++; $display("FAIL cbr_cnt1: got %h want 01", o_REF_CNT); end
        do_read(8'h34, 8'h02, d, oe);
        n_cmp++; if (d !== 4'h1) begin n_bad++; $display("FAIL cbr_no_write: got %h want 1", d); end
        for (int i = 0; i < 255; i++) do_cbr();
        n_cmp++; if (o_REF_CNT !== 8'h00) begin n_bad++; $display("FAIL cbr_wrap: got %h want 00", o_REF_CNT); end
    endtask

    task automatic test_ignored_strobes();
        logic [3:0] d;
        logic       oe;
        i_ADDR = 8'h12; i_WR_n = 1'b0; i_DIN = 4'hE; cyc(3);
        i_WR_n = 1'b1;
        ras_open(8'h12);
        i_ADDR = 8'h0A; i_WR_n = 1'b0; i_DIN = 4'hE; cyc(3);
        i_WR_n = 1'b1;
        ras_close();
        do_read(8'h12, 8'h0A, d, oe);
        n_cmp++; if (d !== 4'h9) begin n_bad++; $display("FAIL ignored_wr: got %h want 9", d); end
        ras_open(8'h56);
        cas_open(8'h0C, 1'b0, 1'b0, 4'h5);
        n_cmp++; if (o_DOUT !== 4'h5 || o_DOUT_OE !== 1'b1) begin
            n_bad++; $display("FAIL wr_through: got dout=%h oe=%b want dout=5 oe=1", o_DOUT, o_DOUT_OE);
        end
        cas_close(); ras_close();
        do_read(8'h56, 8'h0C, d, oe);
        n_cmp++; if (d !== 4'h5) begin n_bad++; $display("FAIL wr_through_array: got %h want 5", d); end
    endtask

    task automatic test_rmw();
        logic [3:0] d;
        logic       oe;
        ras_open(8'h56);
        cas_open(8'h0C, 1'b1, 1'b0, 4'h0);
        n_cmp++; if (o_DOUT !== 4'h5) begin n_bad++; $display("FAIL rmw_read: got %h want 5", o_DOUT); end
        i_RD_n = 1'b1; i_WR_n = 1'b0; i_DIN = 4'h7; cyc(1);
        n_cmp++; if (o_DOUT !== 4'h5 || o_DOUT_OE !== 1'b1) begin
            n_bad++; $display("FAIL rmw_hold: got dout=%h oe=%b want dout=5 oe=1", o_DOUT, o_DOUT_OE);
        end
        cas_close(); ras_close();
        do_read(8'h56, 8'h0C, d, oe);
        n_cmp++; if (d !== 4'h7) begin n_bad++; $display("FAIL rmw_write: got %h want 7", d); end
    endtask

    task automatic test_reset_mid_access();
        logic [3:0] d;
        logic       oe;
        do_write(8'h77, 8'h04, 4'hA);
        do_read(8'h77, 8'h04, d, oe);
        n_cmp++; if (d !== 4'hA) begin n_bad++; $display("FAIL rst_pre_read: got %h want a", d); end
        do_cbr();
        n_cmp++; if (o_REF_CNT !== 8'h01) begin n_bad++; $display("FAIL rst_pre_ref: got %h want 01", o_REF_CNT); end
        ras_open(8'h77);
        i_ADDR = 8'h04; i_WR_n = 1'b0; i_DIN = 4'h3; i_CAS_n = 1'b0;
        cyc(1);
        #2 i_RST_n = 1'b0;
        #1;
        n_cmp++; if (o_DOUT !== 4'h0 || o_DOUT_OE !== 1'b0 || o_REF_CNT !== 8'h00 || o_REF_ERR !== 1'b0) begin
            n_bad++; $display("FAIL rst_async: got dout=%h oe=%b ref=%h err=%b want all 0", o_DOUT, o_DOUT_OE, o_REF_CNT, o_REF_ERR);
        end
        cyc(2);
        i_RST_n = 1'b1;
        cyc(3);
        n_cmp++; if (o_DOUT !== 4'h0 || o_DOUT_OE !== 1'b0) begin
            n_bad++; $display("FAIL rst_held_strobes: got dout=%h oe=%b want 0/0", o_DOUT, o_DOUT_OE);
        end
        i_CAS_n = 1'b1; i_WR_n = 1'b1; i_RAS_n = 1'b1;
        cyc(2);
        do_read(8'h77, 8'h04, d, oe);
        n_cmp++; if (d !== 4'hA) begin n_bad++; $display("FAIL rst_no_commit: got %h want a", d); end
    endtask

    initial begin
        test_reset();
        test_watchdog();
        test_write_read();
        test_page_mode();
        test_cbr();
        test_ignored_strobes();
        test_rmw();
        test_reset_mid_access();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
